// File: rtl/vip_pkg.sv
// Shared encodings for the vip run-time configuration path:
// processing modes, debounce FSM states and threshold limits.
package vip_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_GRAY   = 2'd1;
   localparam logic [1:0] MODE_BIN    = 2'd2;

   localparam logic [7:0] THRESH_MAX  = 8'd255;

   typedef enum logic [1:0] {
      DEB_IDLE,
      DEB_PRESS_WAIT,
      DEB_HELD,
      DEB_REL_WAIT
   } deb_state_e;

   // Mode cycle bypass -> gray -> binary -> bypass; code 3 is never produced.
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_BYPASS: next_mode = MODE_GRAY;
         MODE_GRAY:   next_mode = MODE_BIN;
         default:     next_mode = MODE_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button input: 2-FF synchroniser plus a debounce FSM that
// emits a single-cycle press pulse per physical press (no auto-repeat).
module key_debounce
   import vip_pkg::*;
#(
   parameter int unsigned DEB_CNT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEB_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

   logic          sync1_q, sync2_q;
   deb_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic          press_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DEB_IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         case (state_q)
            DEB_IDLE: begin
               if (!sync2_q) begin
                  cnt_q   <= '0;
                  state_q <= DEB_PRESS_WAIT;
               end
            end
            DEB_PRESS_WAIT: begin
               if (sync2_q) begin
                  state_q <= DEB_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  press_q <= 1'b1;
                  state_q <= DEB_HELD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DEB_HELD: begin
               if (sync2_q) begin
                  cnt_q   <= '0;
                  state_q <= DEB_REL_WAIT;
               end
            end
            DEB_REL_WAIT: begin
               if (!sync2_q) begin
                  state_q <= DEB_HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= DEB_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= DEB_IDLE;
         endcase
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/vip_mode_ctrl.sv
// Push-button driven mode/threshold controller for vip. Requests land in
// shadow registers and are committed only at a frame start (vsync rise).
module vip_mode_ctrl
   import vip_pkg::*;
#(
   parameter int unsigned DEB_CNT     = 1_000_000,
   parameter logic [7:0]  THRESH_INIT = 8'd128,
   parameter logic [7:0]  THRESH_STEP = 8'd8,
   parameter int unsigned FCNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_mode,
   input  logic              key_up,
   input  logic              key_dn,
   input  logic              pre_frame_vsync,
   output logic [1:0]        mode_o,
   output logic [7:0]        thresh_o,
   output logic              mode_pending,
   output logic              cfg_update,
   output logic [FCNT_W-1:0] frame_cnt
);

   logic press_mode, press_up, press_dn;

   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
      .clk(clk), .rst_n(rst_n), .key_i(key_mode), .press_o(press_mode)
   );
   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
      .clk(clk), .rst_n(rst_n), .key_i(key_up), .press_o(press_up)
   );
   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dn (
      .clk(clk), .rst_n(rst_n), .key_i(key_dn), .press_o(press_dn)
   );

   logic [1:0]        sh_mode_q, sh_mode_d;
   logic [7:0]        sh_thr_q, sh_thr_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0]        thr_q, thr_d;
   logic              pending_q, pending_d;
   logic              cfg_upd_q, cfg_upd_d;
   logic              vsync_d1_q;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              fs;
   logic [8:0]        thr_sum;

   assign fs      = pre_frame_vsync & ~vsync_d1_q;
   assign thr_sum = {1'b0, sh_thr_q} + {1'b0, THRESH_STEP};

   always_comb begin
      sh_mode_d = sh_mode_q;
      sh_thr_d  = sh_thr_q;
      mode_d    = mode_q;
      thr_d     = thr_q;
      cfg_upd_d = 1'b0;
      fcnt_d    = fcnt_q;

      if (press_mode) sh_mode_d = next_mode(sh_mode_q);

      if (press_up && !press_dn) begin
         sh_thr_d = thr_sum[8] ? THRESH_MAX : thr_sum[7:0];
      end else if (press_dn && !press_up) begin
         sh_thr_d = (sh_thr_q < THRESH_STEP) ? 8'd0 : sh_thr_q - THRESH_STEP;
      end

      // Commit takes the pre-press shadow; a coincident press stays pending.
      if (fs) begin
         fcnt_d = fcnt_q + 1'b1;
         if (pending_q) begin
            mode_d    = sh_mode_q;
            thr_d     = sh_thr_q;
            cfg_upd_d = 1'b1;
         end
      end

      pending_d = (sh_mode_d != mode_d) || (sh_thr_d != thr_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_mode_q  <= MODE_BYPASS;
         sh_thr_q   <= THRESH_INIT;
         mode_q     <= MODE_BYPASS;
         thr_q      <= THRESH_INIT;
         pending_q  <= 1'b0;
         cfg_upd_q  <= 1'b0;
         vsync_d1_q <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         sh_mode_q  <= sh_mode_d;
         sh_thr_q   <= sh_thr_d;
         mode_q     <= mode_d;
         thr_q      <= thr_d;
         pending_q  <= pending_d;
         cfg_upd_q  <= cfg_upd_d;
         vsync_d1_q <= pre_frame_vsync;
         fcnt_q     <= fcnt_d;
      end
   end

   assign mode_o       = mode_q;
   assign thresh_o     = thr_q;
   assign mode_pending = pending_q;
   assign cfg_update   = cfg_upd_q;
   assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_vip_mode_ctrl.sv
// Directed bench for vip_mode_ctrl with short debounce and a 4-bit frame counter.
module tb_vip_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode = 1'b1, key_up = 1'b1, key_dn = 1'b1;
   logic       vsync = 1'b0;
   logic [1:0] mode_o;
   logic [7:0] thresh_o;
   logic       mode_pending, cfg_update;
   logic [3:0] frame_cnt;

   int unsigned checks = 0, failures = 0;
   int unsigned cfg_cycles = 0;
   int unsigned exp_cfg = 0;
   int unsigned exp_frame = 0;

   vip_mode_ctrl #(.DEB_CNT(16), .THRESH_INIT(8'd128), .THRESH_STEP(8'd8), .FCNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_mode(key_mode), .key_up(key_up), .key_dn(key_dn),
      .pre_frame_vsync(vsync),
      .mode_o(mode_o), .thresh_o(thresh_o),
      .mode_pending(mode_pending), .cfg_update(cfg_update),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (cfg_update) cfg_cycles++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_keys(input logic [2:0] sel, input logic lvl);
      if (sel[0]) key_mode = lvl;
      if (sel[1]) key_up   = lvl;
      if (sel[2]) key_dn   = lvl;
   endtask

   // sel bits: 0 mode, 1 up, 2 dn
   task automatic press(input logic [2:0] sel, input bit bounce);
      if (bounce) begin
         @(negedge clk) set_keys(sel, 1'b0);
         @(negedge clk) set_keys(sel, 1'b1);
         @(negedge clk) set_keys(sel, 1'b0);
      end
      @(negedge clk) set_keys(sel, 1'b0);
      repeat (40) @(negedge clk);
      if (bounce) begin
         set_keys(sel, 1'b1);
         @(negedge clk) set_keys(sel, 1'b0);
         @(negedge clk) set_keys(sel, 1'b1);
      end
      @(negedge clk) set_keys(sel, 1'b1);
      repeat (30) @(negedge clk);
   endtask

   task automatic vsync_pulse(input int unsigned high_cycles);
      @(negedge clk) vsync = 1'b1;
      exp_frame++;
      repeat (high_cycles) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_mode", 32'(mode_o), 0);
      chk("rst_thr", 32'(thresh_o), 128);
      chk("rst_pend", 32'(mode_pending), 0);
      chk("rst_fcnt", 32'(frame_cnt), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      vsync_pulse(4);
      chk("v1_mode", 32'(mode_o), 0);
      chk("v1_thr", 32'(thresh_o), 128);
      chk("v1_fcnt", 32'(frame_cnt), exp_frame);
      chk("v1_cfg", cfg_cycles, exp_cfg);

      press(3'b001, 1'b1);
      chk("bm_pend", 32'(mode_pending), 1);
      chk("bm_mode_hold", 32'(mode_o), 0);
      vsync_pulse(4);
      exp_cfg++;
      chk("bm_mode", 32'(mode_o), 1);
      chk("bm_cfg", cfg_cycles, exp_cfg);
      chk("bm_pend_clr", 32'(mode_pending), 0);

      for (int i = 0; i < 17; i++) press(3'b010, 1'b0);
      chk("up_pend", 32'(mode_pending), 1);
      vsync_pulse(4);
      exp_cfg++;
      chk("up_sat", 32'(thresh_o), 255);
      chk("up_cfg", cfg_cycles, exp_cfg);

      for (int i = 0; i < 33; i++) press(3'b100, 1'b0);
      vsync_pulse(4);
      exp_cfg++;
      chk("dn_sat", 32'(thresh_o), 0);
      chk("dn_fcnt", 32'(frame_cnt), exp_frame);

      press(3'b110, 1'b0);
      chk("ud_pend", 32'(mode_pending), 0);
      vsync_pulse(4);
      chk("ud_thr", 32'(thresh_o), 0);
      chk("ud_cfg", cfg_cycles, exp_cfg);

      // Mode press pulse lands on the same edge as the vsync rise.
      @(negedge clk) key_mode = 1'b0;
      repeat (19) @(negedge clk);
      vsync = 1'b1;
      exp_frame++;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (25) @(negedge clk);
      key_mode = 1'b1;
      repeat (30) @(negedge clk);
      chk("sc_mode_hold", 32'(mode_o), 1);
      chk("sc_pend", 32'(mode_pending), 1);
      chk("sc_cfg", cfg_cycles, exp_cfg);
      vsync_pulse(4);
      exp_cfg++;
      chk("sc_mode", 32'(mode_o), 2);

      for (int i = 0; i < 8; i++) press(3'b010, 1'b0);
      vsync_pulse(4);
      exp_cfg++;
      chk("t64_thr", 32'(thresh_o), 64);
      chk("t64_mode", 32'(mode_o), 2);
      chk("t64_cfg", cfg_cycles, exp_cfg);

      // Long vsync gives one frame start; reset lands mid-frame, mid-debounce.
      @(negedge clk) vsync = 1'b1;
      exp_frame++;
      key_up = 1'b0;
      repeat (12) @(negedge clk);
      chk("long_vs_fcnt", 32'(frame_cnt), exp_frame);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_mode", 32'(mode_o), 0);
      chk("ar_thr", 32'(thresh_o), 128);
      chk("ar_fcnt", 32'(frame_cnt), 0);
      chk("ar_pend", 32'(mode_pending), 0);
      key_up = 1'b1;
      vsync = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_frame = 0;
      repeat (30) @(negedge clk);
      chk("ar_no_press", 32'(mode_pending), 0);

      for (int i = 0; i < 15; i++) vsync_pulse(2);
      chk("wrap_15", 32'(frame_cnt), 15);
      vsync_pulse(2);
      chk("wrap_0", 32'(frame_cnt), 0);
      chk("wrap_thr", 32'(thresh_o), 128);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
